// File: rtl/lgn_image_feeder.sv
// rtl/lgn_image_feeder.sv - row-stream to byte-load feeder and result decoder for the LGN classifier
// Optional abort input is compiled in when LGN_FEEDER_ABORT_EN is defined.
module lgn_image_feeder #(
    parameter int ROW_BITS      = 28,
    parameter int ROWS          = 28,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROW_BITS-1:0] row_data,
    input  logic                row_valid,
    output logic                row_ready,
`ifdef LGN_FEEDER_ABORT_EN
    input  logic                abort,
`endif
    output logic                lgn_write_enable,
    output logic [7:0]          lgn_ui_in,
    input  logic [15:0]         lgn_uo_out,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [3:0]          result_index,
    output logic [7:0]          result_value,
    output logic                result_error,
    output logic                busy
);
    localparam int BUF_W       = ROW_BITS + 8;
    localparam int FILL_W      = $clog2(BUF_W + 1);
    localparam int TOTAL_BYTES = ROW_BITS * ROWS / 8;

    localparam logic [FILL_W-1:0] BYTE_FILL   = FILL_W'(8);
    localparam logic [FILL_W-1:0] ROW_FILL    = FILL_W'(ROW_BITS);
    localparam logic [4:0]        ROWS_L      = 5'(ROWS);
    localparam logic [6:0]        BYTES_L     = 7'(TOTAL_BYTES);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BUF_W-1:0]  bit_buf;
    logic [BUF_W-1:0]  buf_shift;
    logic [BUF_W-1:0]  buf_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_after;
    logic [FILL_W-1:0] fill_next;
    logic [4:0]        rows_accepted;
    logic [6:0]        bytes_sent;
    logic [3:0]        settle_cnt;
    logic              armed;
    logic              accept;
    logic              emit;
    logic              capture;
    logic              release_result;
    logic              clear;
    logic              abort_hit;
    logic [3:0]        dec_index;
    logic              dec_bad;

`ifdef LGN_FEEDER_ABORT_EN
    assign abort_hit = abort && (state == S_LOAD || state == S_SETTLE);
`else
    assign abort_hit = 1'b0;
`endif

    // armed keeps row_ready low until the first clock edge after reset releases
    assign row_ready = armed && (state == S_IDLE || state == S_LOAD) && (fill < BYTE_FILL)
                       && (rows_accepted < ROWS_L) && !abort_hit;
    assign accept         = row_valid && row_ready;
    assign emit           = (state == S_LOAD) && (fill >= BYTE_FILL) && !abort_hit;
    assign capture        = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST) && !abort_hit;
    assign release_result = (state == S_RESULT) && result_ready;
    assign clear          = abort_hit || release_result;
    assign busy           = (state != S_IDLE);

    // Buffer is MSB-aligned: oldest pixel at the top, bits below fill kept zero
    always_comb begin
        buf_shift  = bit_buf;
        fill_after = fill;
        if (emit) begin
            buf_shift  = bit_buf << 8;
            fill_after = fill - BYTE_FILL;
        end
        buf_next  = buf_shift;
        fill_next = fill_after;
        if (accept) begin
            buf_next  = buf_shift | ({row_data, 8'h00} >> fill_after);
            fill_next = fill_after + ROW_FILL;
        end
    end

    always_comb begin
        dec_index = 4'hF;
        dec_bad   = 1'b0;
        case (lgn_uo_out[6:0])
            7'h3F:   dec_index = 4'd0;
            7'h06:   dec_index = 4'd1;
            7'h5B:   dec_index = 4'd2;
            7'h4F:   dec_index = 4'd3;
            7'h66:   dec_index = 4'd4;
            7'h6D:   dec_index = 4'd5;
            7'h7C:   dec_index = 4'd6;
            7'h07:   dec_index = 4'd7;
            7'h7F:   dec_index = 4'd8;
            7'h67:   dec_index = 4'd9;
            default: dec_bad   = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_LOAD;
            S_LOAD:   if (bytes_sent == BYTES_L) state_next = S_SETTLE;
            S_SETTLE: if (capture) state_next = S_RESULT;
            S_RESULT: if (result_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort_hit) state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed            <= 1'b0;
            bit_buf          <= '0;
            fill             <= '0;
            rows_accepted    <= '0;
            bytes_sent       <= '0;
            settle_cnt       <= '0;
            lgn_write_enable <= 1'b0;
            lgn_ui_in        <= 8'h00;
            result_valid     <= 1'b0;
            result_index     <= 4'h0;
            result_value     <= 8'h00;
            result_error     <= 1'b0;
        end else begin
            armed            <= 1'b1;
            lgn_write_enable <= emit;
            lgn_ui_in        <= emit ? bit_buf[BUF_W-1 -: 8] : 8'h00;
            if (clear) begin
                bit_buf       <= '0;
                fill          <= '0;
                rows_accepted <= '0;
                bytes_sent    <= '0;
            end else begin
                bit_buf <= buf_next;
                fill    <= fill_next;
                if (accept && rows_accepted != ROWS_L) rows_accepted <= rows_accepted + 5'd1;
                if (emit) bytes_sent <= bytes_sent + 7'd1;
            end
            if (state == S_SETTLE && !capture && !abort_hit) settle_cnt <= settle_cnt + 4'd1;
            else                                             settle_cnt <= '0;
            if (capture) begin
                result_valid <= 1'b1;
                result_index <= dec_index;
                result_value <= lgn_uo_out[15:8];
                result_error <= dec_bad | ~lgn_uo_out[7];
            end else if (release_result) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lgn_image_feeder.sv
// tb/tb_lgn_image_feeder.sv - self-checking bench for lgn_image_feeder
`timescale 1ns/1ps
module tb_lgn_image_feeder;
    localparam int ROW_BITS      = 28;
    localparam int ROWS          = 28;
    localparam int SETTLE_CYCLES = 2;
    localparam int TOTAL_BITS    = ROW_BITS * ROWS;
    localparam int TOTAL_BYTES   = TOTAL_BITS / 8;
    localparam logic [15:0] DECOY = 16'h00FF;
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

    logic                clk;
    logic                rst;
    logic [ROW_BITS-1:0] row_data;
    logic                row_valid;
    logic                row_ready;
    logic                lgn_write_enable;
    logic [7:0]          lgn_ui_in;
    logic [15:0]         lgn_uo_out;
    logic                result_valid;
    logic                result_ready;
    logic [3:0]          result_index;
    logic [7:0]          result_value;
    logic                result_error;
    logic                busy;
`ifdef LGN_FEEDER_ABORT_EN
    logic                abort = 1'b0;
`endif

    lgn_image_feeder #(
        .ROW_BITS(ROW_BITS),
        .ROWS(ROWS),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row_data(row_data),
        .row_valid(row_valid),
        .row_ready(row_ready),
`ifdef LGN_FEEDER_ABORT_EN
        .abort(abort),
`endif
        .lgn_write_enable(lgn_write_enable),
        .lgn_ui_in(lgn_ui_in),
        .lgn_uo_out(lgn_uo_out),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_index(result_index),
        .result_value(result_value),
        .result_error(result_error),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ROW_BITS-1:0] img [ROWS];
    logic [7:0]          exp_bytes [TOTAL_BYTES];
    logic [7:0]          obs_bytes [TOTAL_BYTES];
    logic [15:0]         good_uo;
    int                  byte_idx;
    int                  rows_acc;
    int                  since;
    int                  n_checks;
    int                  n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole image as one 784-bit word, pixel 0 of row 0 at the top bit
    function automatic void build_expect();
        logic [TOTAL_BITS-1:0] bits;
        bits = '0;
        for (int p = 0; p < TOTAL_BITS; p++)
            bits[TOTAL_BITS-1-p] = img[p / ROW_BITS][ROW_BITS-1-(p % ROW_BITS)];
        for (int k = 0; k < TOTAL_BYTES; k++)
            exp_bytes[k] = bits[TOTAL_BITS-1-8*k -: 8];
    endfunction

    function automatic logic [12:0] model_result(input logic [15:0] uo);
        logic [3:0] idx;
        logic       err;
        idx = 4'hF;
        err = 1'b1;
        for (int i = 0; i < 10; i++)
            if (uo[6:0] == SEG[i]) begin
                idx = 4'(i);
                err = 1'b0;
            end
        if (!uo[7]) err = 1'b1;
        return {err, uo[15:8], idx};
    endfunction

    // Compare process; also stubs lgn_uo_out so the real word is present only in the capture cycle
    always @(negedge clk) begin
        logic [12:0] r;
        if (rst) begin
            byte_idx   = 0;
            rows_acc   = 0;
            since      = 1000;
            lgn_uo_out = DECOY;
        end else begin
            if (rows_acc >= ROWS) chk("ready_after_last_row", row_ready, 0);
            if (row_valid && row_ready) rows_acc++;
            if (lgn_write_enable) begin
                if (byte_idx < TOTAL_BYTES) begin
                    chk($sformatf("byte%0d", byte_idx), lgn_ui_in, exp_bytes[byte_idx]);
                    obs_bytes[byte_idx] = lgn_ui_in;
                end else begin
                    chk("extra_byte", byte_idx, TOTAL_BYTES - 1);
                end
                byte_idx++;
                since = 0;
            end else if (since < 1000) begin
                since++;
            end
            if (result_valid) begin
                r = model_result(good_uo);
                chk("res_index", result_index, r[3:0]);
                chk("res_value", result_value, r[11:4]);
                chk("res_error", result_error, r[12]);
                chk("res_busy", busy, 1);
                chk("res_row_ready", row_ready, 0);
                chk("res_no_we", lgn_write_enable, 0);
            end
            if (result_valid && result_ready) begin
                rows_acc = 0;
                byte_idx = 0;
            end
            lgn_uo_out = (since == SETTLE_CYCLES) ? good_uo : DECOY;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_row_ready"}, row_ready, 0);
        chk({tag, "_we"}, lgn_write_enable, 0);
        chk({tag, "_ui_in"}, lgn_ui_in, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_index"}, result_index, 0);
        chk({tag, "_result_value"}, result_value, 0);
        chk({tag, "_result_error"}, result_error, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic drive_rows(input int n);
        for (int r = 0; r < n; r++) begin
            int g;
            g = 0;
            row_data  = img[r];
            row_valid = 1'b1;
            @(negedge clk);
            while (!row_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            chk("row_accept", row_ready, 1);
            @(posedge clk);
            #1;
        end
        row_valid = 1'b0;
        row_data  = '0;
    endtask

    task automatic run_image(input string tag, input logic [15:0] uo, input logic [3:0] lit_idx,
                             input logic [7:0] lit_val, input logic lit_err, input int hold);
        int g;
        build_expect();
        good_uo = uo;
        drive_rows(ROWS);
        g = 0;
        while (!result_valid && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_result_seen"}, result_valid, 1);
        chk({tag, "_byte_count"}, byte_idx, TOTAL_BYTES);
        chk({tag, "_lit_index"}, result_index, lit_idx);
        chk({tag, "_lit_value"}, result_value, lit_val);
        chk({tag, "_lit_error"}, result_error, lit_err);
        repeat (hold) @(negedge clk);
        chk({tag, "_held_valid"}, result_valid, 1);
        chk({tag, "_held_index"}, result_index, lit_idx);
        @(posedge clk);
        #1 result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, result_valid, 0);
        chk({tag, "_ready_back"}, row_ready, 1);
        chk({tag, "_idle"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        row_valid    = 1'b0;
        row_data     = '0;
        result_ready = 1'b0;
        good_uo      = DECOY;
        lgn_uo_out   = DECOY;
        for (int r = 0; r < ROWS; r++) img[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", row_ready, 1);
        @(posedge clk);
        #1;

        for (int r = 0; r < ROWS; r++) img[r] = 28'hFFFFFFF;
        run_image("ones", 16'hA5DB, 4'd2, 8'hA5, 1'b0, 10);
        chk("ones_last_byte", obs_bytes[TOTAL_BYTES-1], 8'hFF);

        for (int r = 0; r < ROWS; r++) img[r] = '0;
        img[0] = 28'h8000000;
        run_image("first_px", 16'h1080, 4'hF, 8'h10, 1'b1, 1);
        chk("first_px_byte0", obs_bytes[0], 8'h80);
        chk("first_px_byte1", obs_bytes[1], 8'h00);

        img[0] = 28'h0000001;
        run_image("px27", 16'h3006, 4'd1, 8'h30, 1'b1, 1);
        chk("px27_byte3", obs_bytes[3], 8'h10);
        chk("px27_byte2", obs_bytes[2], 8'h00);

        for (int r = 0; r < ROWS; r++) img[r] = 28'h5A5A5A5 ^ 28'(r * 28'h0123457);
        build_expect();
        good_uo = DECOY;
        drive_rows(12);
        g = 0;
        while (byte_idx < 40 && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("midload_reached_40", byte_idx >= 40, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midload");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_midload_reset", row_ready, 1);
        @(posedge clk);
        #1;

        for (int r = 0; r < ROWS; r++) img[r] = 28'(32'h9E3779B9 * (r + 1));
        run_image("after_reset", 16'h3CED, 4'd5, 8'h3C, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
